// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: state encoding, widths and
// the x0 register index.
package memory_stage_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned CNT_W     = 8;   // wide enough for TIMEOUT up to 255

    localparam logic [REG_IDX_W-1:0] REG_X0 = REG_IDX_W'(0);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with bubble insertion.
// Ports:
//   clk, rst            clock, async active-high reset
//   stall               hold data/rd and insert a bubble (we=0)
//   wb_data_d/rd_d/we_d next-state values from the MEM stage
//   WB_DATA/WB_RD/WB_WE registered write-back outputs
module mem_wb_reg
    import memory_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [XLEN-1:0]      wb_data_d,
    input  logic [REG_IDX_W-1:0] wb_rd_d,
    input  logic                 wb_we_d,
    output logic [XLEN-1:0]      WB_DATA,
    output logic [REG_IDX_W-1:0] WB_RD,
    output logic                 WB_WE
);

    // Stall keeps data/rd so the bypass value stays coherent; only we drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_DATA <= '0;
            WB_RD   <= '0;
            WB_WE   <= 1'b0;
        end else if (stall) begin
            WB_WE   <= 1'b0;
        end else begin
            WB_DATA <= wb_data_d;
            WB_RD   <= wb_rd_d;
            WB_WE   <= wb_we_d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: data-memory access over a req/ack handshake, stall
// generation while an access is outstanding, access timeout, MEM/WB register
// and forwarding bypass values.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned memops
// (no request, no write-back, one-cycle MISALIGN pulse).
// Ports:
//   clk, rst                               clock, async active-high reset
//   ALU_OUT, WD, RD, ME_WE                 execute-stage results/control
//   MEM_WE_ME, MEM_REG_ME                  store / load request
//   DM_REQ, DM_WE, DM_ADDR, DM_WDATA       data-memory request (combinational)
//   DM_RDATA, DM_ACK                       data-memory response
//   STALL                                  freeze upstream pipeline
//   BP_MEM, BP_WB                          forwarding values
//   WB_DATA, WB_RD, WB_WE                  MEM/WB register
//   MISALIGN                               (MEM_ALIGN_CHECK_EN only)
//   BUS_ERR                                one-cycle timeout pulse
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      ALU_OUT,
    input  logic [XLEN-1:0]      WD,
    input  logic [REG_IDX_W-1:0] RD,
    input  logic                 ME_WE,
    input  logic                 MEM_WE_ME,
    input  logic                 MEM_REG_ME,
    output logic                 DM_REQ,
    output logic                 DM_WE,
    output logic [XLEN-1:0]      DM_ADDR,
    output logic [XLEN-1:0]      DM_WDATA,
    input  logic [XLEN-1:0]      DM_RDATA,
    input  logic                 DM_ACK,
    output logic                 STALL,
    output logic [XLEN-1:0]      BP_MEM,
    output logic [XLEN-1:0]      BP_WB,
    output logic [XLEN-1:0]      WB_DATA,
    output logic [REG_IDX_W-1:0] WB_RD,
    output logic                 WB_WE,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                 MISALIGN,
`endif
    output logic                 BUS_ERR
);

    state_e             state;
    logic [CNT_W-1:0]   count;

    logic               memop_c;
    logic               is_load_c;
    logic               misalign_c;
    logic               req_c;
    logic               abandon_c;
    logic [XLEN-1:0]    wb_data_d;
    logic               wb_we_d;

    assign memop_c   = MEM_WE_ME | MEM_REG_ME;
    // Store wins when both are requested, so it is only a load without a store.
    assign is_load_c = MEM_REG_ME & ~MEM_WE_ME;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = memop_c & (ALU_OUT[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    assign req_c     = memop_c & ~misalign_c;
    assign abandon_c = (state == WAIT) & ~DM_ACK & (count == CNT_W'(TIMEOUT));

    // Memory interface; upstream holds these stable while stalled.
    assign DM_REQ   = ~rst & ((state == WAIT) | req_c);
    assign DM_WE    = MEM_WE_ME;
    assign DM_ADDR  = ALU_OUT;
    assign DM_WDATA = WD;

    // Stall drops in the cycle the access completes or is abandoned.
    assign STALL = DM_REQ & ~DM_ACK & ~abandon_c;

    assign BP_MEM = ALU_OUT;
    assign BP_WB  = WB_DATA;

    // Write-back next values; a failed load writes nothing and zeroes data.
    always_comb begin
        wb_data_d = ALU_OUT;
        if (is_load_c) begin
            wb_data_d = (abandon_c | misalign_c) ? '0 : DM_RDATA;
        end
        wb_we_d = ME_WE & (RD != REG_X0) & ~(is_load_c & abandon_c) & ~misalign_c;
    end

    // Access FSM with wait-cycle counter and timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            BUS_ERR <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            MISALIGN <= 1'b0;
`endif
        end else begin
            BUS_ERR <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            MISALIGN <= misalign_c & (state == IDLE);
`endif
            case (state)
                IDLE: begin
                    if (req_c & ~DM_ACK) begin
                        state <= WAIT;
                        count <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (DM_ACK) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == CNT_W'(TIMEOUT)) begin
                        state   <= IDLE;
                        count   <= '0;
                        BUS_ERR <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    mem_wb_reg #(
        .XLEN (XLEN)
    ) u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .stall     (STALL),
        .wb_data_d (wb_data_d),
        .wb_rd_d   (RD),
        .wb_we_d   (wb_we_d),
        .WB_DATA   (WB_DATA),
        .WB_RD     (WB_RD),
        .WB_WE     (WB_WE)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the driver pushes the expected MEM/WB
// contents per operation, a monitor pops and compares on every retire edge.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_OUT, WD, DM_RDATA;
    logic [4:0]  RD;
    logic        ME_WE, MEM_WE_ME, MEM_REG_ME, DM_ACK;
    logic        DM_REQ, DM_WE, STALL, WB_WE, BUS_ERR;
    logic [31:0] DM_ADDR, DM_WDATA, BP_MEM, BP_WB, WB_DATA;
    logic [4:0]  WB_RD;
`ifdef MEM_ALIGN_CHECK_EN
    logic        MISALIGN;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } wb_t;

    wb_t  exp_q[$];
    wb_t  mon_e;
    int   errors = 0;
    int   checks = 0;
    logic issuing = 1'b0;
    logic mon_ret, mon_bub;

    always #5 clk = ~clk;

    memory_stage #(.XLEN(32), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALU_OUT    (ALU_OUT),
        .WD         (WD),
        .RD         (RD),
        .ME_WE      (ME_WE),
        .MEM_WE_ME  (MEM_WE_ME),
        .MEM_REG_ME (MEM_REG_ME),
        .DM_REQ     (DM_REQ),
        .DM_WE      (DM_WE),
        .DM_ADDR    (DM_ADDR),
        .DM_WDATA   (DM_WDATA),
        .DM_RDATA   (DM_RDATA),
        .DM_ACK     (DM_ACK),
        .STALL      (STALL),
        .BP_MEM     (BP_MEM),
        .BP_WB      (BP_WB),
        .WB_DATA    (WB_DATA),
        .WB_RD      (WB_RD),
        .WB_WE      (WB_WE),
`ifdef MEM_ALIGN_CHECK_EN
        .MISALIGN   (MISALIGN),
`endif
        .BUS_ERR    (BUS_ERR)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an edge with no stall while an op is presented retires it.
    always @(posedge clk) begin
        mon_ret = issuing & ~rst & ~STALL;
        mon_bub = issuing & ~rst & STALL;
        #1;
        if (mon_ret) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got retire expected none at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_data", WB_DATA, mon_e.data);
                chk("wb_rd",   32'(WB_RD), 32'(mon_e.rd));
                chk("wb_we",   32'(WB_WE), 32'(mon_e.we));
                chk("bp_wb",   BP_WB, mon_e.data);
            end
        end
        if (mon_bub) chk("bubble_wb_we", 32'(WB_WE), 32'd0);
    end

    task automatic go_idle();
        ALU_OUT    = 32'h0;
        WD         = 32'h0;
        RD         = 5'd0;
        ME_WE      = 1'b0;
        MEM_WE_ME  = 1'b0;
        MEM_REG_ME = 1'b0;
        DM_ACK     = 1'b1;   // ack with no request must be ignored
        issuing    = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic mewe, input logic st, input logic ld,
                          input int ack_at, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic exp_we,
                          input int exp_stall, input logic exp_err);
        int stalls;
        int cyc;
        exp_q.push_back({exp_data, rd, exp_we});
        @(negedge clk);
        ALU_OUT = alu; WD = wd; RD = rd; ME_WE = mewe;
        MEM_WE_ME = st; MEM_REG_ME = ld; DM_RDATA = rdata;
        DM_ACK = (ack_at == 0); issuing = 1'b1;
        stalls = 0;
        cyc = 0;
        forever begin
            #1;
            chk({name, "_bp_mem"}, BP_MEM, alu);
            if (st | ld) begin
                chk({name, "_dm_req"},  32'(DM_REQ), 32'd1);
                chk({name, "_dm_addr"}, DM_ADDR, alu);
                chk({name, "_dm_we"},   32'(DM_WE), 32'(st));
                if (st) chk({name, "_dm_wdata"}, DM_WDATA, wd);
            end else begin
                chk({name, "_dm_req"},  32'(DM_REQ), 32'd0);
            end
            if (!STALL) break;
            stalls++;
            if (cyc >= 300) begin
                chk({name, "_stall_bound"}, 32'(cyc), 32'd0);
                break;
            end
            @(negedge clk);
            cyc++;
            DM_ACK = (cyc == ack_at);
        end
        chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk);
        #1;
        chk({name, "_bus_err"}, 32'(BUS_ERR), 32'(exp_err));
        @(negedge clk);
        go_idle();
        @(posedge clk);
        #1;
        chk({name, "_bus_err_after"}, 32'(BUS_ERR), 32'd0);
        chk({name, "_stall_after"},   32'(STALL), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        DM_RDATA = 32'h0;
        go_idle();
        MEM_REG_ME = 1'b1;   // request must be masked by reset
        DM_ACK = 1'b0;
        #2;
        chk("rst_wb_data", WB_DATA, 32'h0);
        chk("rst_wb_rd",   32'(WB_RD), 32'd0);
        chk("rst_wb_we",   32'(WB_WE), 32'd0);
        chk("rst_bus_err", 32'(BUS_ERR), 32'd0);
        chk("rst_dm_req",  32'(DM_REQ), 32'd0);
        chk("rst_stall",   32'(STALL), 32'd0);
        @(negedge clk);
        go_idle();
        rst = 1'b0;

        //     name     alu           wd            rd  we st ld ack rdata         exp_data      we stl err
        run_op("alu",   32'h00000123, 32'h0,        5,  1, 0, 0, 0,  32'h0,        32'h00000123, 1, 0,  0);
        run_op("ld0",   32'h00000040, 32'h0,        2,  1, 0, 1, 0,  32'hDEADBEEF, 32'hDEADBEEF, 1, 0,  0);
        run_op("ld3",   32'h00000044, 32'h0,        6,  1, 0, 1, 3,  32'hCAFEF00D, 32'hCAFEF00D, 1, 3,  0);
        run_op("st1",   32'h00000080, 32'h55AA55AA, 7,  0, 1, 0, 1,  32'h0,        32'h00000080, 0, 1,  0);
        run_op("ldto",  32'h00000048, 32'h0,        3,  1, 0, 1, -1, 32'h12345678, 32'h00000000, 0, 15, 1);
        run_op("alu2",  32'h00000777, 32'h0,        9,  1, 0, 0, 0,  32'h0,        32'h00000777, 1, 0,  0);

        // Reset in the middle of a wait: everything drops at once.
        @(negedge clk);
        ALU_OUT = 32'h100; RD = 5'd4; ME_WE = 1'b1; MEM_REG_ME = 1'b1;
        DM_ACK = 1'b0; issuing = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("midwait_stall", 32'(STALL), 32'd1);
        issuing = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_dm_req",  32'(DM_REQ), 32'd0);
        chk("midrst_stall",   32'(STALL), 32'd0);
        chk("midrst_wb_we",   32'(WB_WE), 32'd0);
        chk("midrst_wb_data", WB_DATA, 32'h0);
        chk("midrst_wb_rd",   32'(WB_RD), 32'd0);
        chk("midrst_bus_err", 32'(BUS_ERR), 32'd0);
        @(negedge clk);
        go_idle();
        rst = 1'b0;

        run_op("x0",    32'h00000abc, 32'h0,        0,  1, 0, 0, 0,  32'h0,        32'h00000abc, 0, 0,  0);
        run_op("ld2",   32'h00000050, 32'h0,        31, 1, 0, 1, 2,  32'h0BADF00D, 32'h0BADF00D, 1, 2,  0);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes execute's registered outputs: ALU result, store data, destination register, memory and write-back control.
- Performs data-memory loads and stores over a req/ack handshake and stalls the pipeline while an access is outstanding.
- Registers the MEM/WB pipeline register and drives the bypass values used by the execute stage's forwarding muxes.

Parameters:
- XLEN, 32, datapath width.
- TIMEOUT, 15, max cycles to wait for DM_ACK before the access is abandoned (range 1..255).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ALU_OUT  in  XLEN  address for a memory op; result for a non-memory op
- WD  in  XLEN  store data (execute's forwarded D2)
- RD  in  5  destination register
- ME_WE  in  1  register write-back enable
- MEM_WE_ME  in  1  store request
- MEM_REG_ME  in  1  load request (write-back selects memory data)
- DM_REQ  out  1  data-memory request
- DM_WE  out  1  data-memory write
- DM_ADDR  out  XLEN  data-memory address
- DM_WDATA  out  XLEN  data-memory write data
- DM_RDATA  in  XLEN  data-memory read data, valid with DM_ACK
- DM_ACK  in  1  data-memory completion strobe
- STALL  out  1  to hazard unit: freeze PC, IF/ID, ID/EX and EX/MEM
- BP_MEM  out  XLEN  bypass from this stage (= ALU_OUT)
- BP_WB  out  XLEN  bypass from write-back (= WB_DATA)
- WB_DATA  out  XLEN  registered write-back value
- WB_RD  out  5  registered destination register
- WB_WE  out  1  registered write enable
- BUS_ERR  out  1  one-cycle pulse when an access times out

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, WB_DATA=0, WB_RD=0, WB_WE=0, BUS_ERR=0.
  - Combinational outputs are forced low during reset: DM_REQ=0, STALL=0.
- memop = MEM_WE_ME | MEM_REG_ME. If both are set, the store wins (DM_WE=1) and no load write-back occurs.
- DM_ADDR=ALU_OUT, DM_WDATA=WD, DM_WE=MEM_WE_ME. These are combinational; upstream holds them stable while STALL=1.
- FSM has two states, IDLE and WAIT.
  - IDLE: DM_REQ=memop.
    - memop & DM_ACK: zero-stall completion, stay IDLE.
    - memop & !DM_ACK: go to WAIT, counter<=1.
  - WAIT: DM_REQ=1.
    - DM_ACK: go to IDLE, counter<=0.
    - Else if counter==TIMEOUT: BUS_ERR<=1 for one cycle, go to IDLE, access abandoned.
    - Else counter<=counter+1.
- STALL = DM_REQ & !DM_ACK & !(state==WAIT & counter==TIMEOUT). STALL drops in the cycle the access completes or is abandoned.
- MEM/WB register, when !STALL, at the rising edge:
  - WB_DATA <= MEM_REG_ME ? DM_RDATA : ALU_OUT.
  - WB_RD <= RD.
  - WB_WE <= ME_WE & (RD!=0) & !(timeout abandon on a load).
  - On a load abandon, WB_DATA <= 0.
- MEM/WB register, when STALL: bubble insertion, WB_WE<=0. WB_DATA and WB_RD hold.
- Non-memory ops: single-cycle pass-through, never stall.
- Latency: one cycle from inputs to WB_* with an immediate ack; N+1 cycles with ack on wait cycle N.
- DM_ACK while DM_REQ=0: ignored.
- Reset mid-WAIT: access dropped immediately, no write-back, no BUS_ERR.
- BP_MEM and BP_WB are purely combinational.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined:
  - A memop with ALU_OUT[1:0]!=0 suppresses DM_REQ and does not stall.
  - Write-back is suppressed (WB_WE<=0).
  - Extra output MISALIGN (1 bit) is registered high for one cycle.
- When undefined:
  - No MISALIGN port.
  - Addresses pass to memory unchecked; the low bits are the memory's concern.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE=1'b0, WAIT=1'b1.
  - XLEN default.
  - Register index width (5).
  - The x0 index constant.
- Optional sub-module: mem_wb_reg, the MEM/WB pipeline register with stall/bubble control. The FSM and counter stay in memory_stage.

Test Plan:
- Reset then ALU op: ALU_OUT=0x00000123, RD=5, ME_WE=1, no memop → next edge WB_DATA=0x123, WB_RD=5, WB_WE=1, STALL never asserts.
- Load, ack same cycle: MEM_REG_ME=1, ALU_OUT=0x40, DM_RDATA=0xDEADBEEF, DM_ACK=1 → DM_REQ=1, STALL=0, next edge WB_DATA=0xDEADBEEF, WB_WE=1.
- Load, ack on 3rd wait cycle:
  - STALL high for exactly 3 cycles.
  - WB_WE=0 during the stall.
  - One write-back of DM_RDATA after ack.
  - DM_ADDR stable throughout.
- Store: MEM_WE_ME=1, ALU_OUT=0x80, WD=0x55AA55AA, ME_WE=0, ack after 1 wait → DM_WE=1, DM_WDATA=0x55AA55AA, WB_WE=0.
- Timeout: load with DM_ACK held 0 → BUS_ERR pulses once when counter==15, STALL then drops, WB_WE=0, WB_DATA=0, FSM back in IDLE.
- Reset mid-WAIT, and x0 write:
  - Assert rst during WAIT → DM_REQ and STALL drop immediately; WB_* = 0.
  - ALU op with RD=0, ME_WE=1 → WB_WE=0.
